pad_in_filter: RTL

//  Conditions the raw pad-side inputs coming out of the pad frame (in_* / bootsel nets) before they reach peripherals.
//  Per channel: N-stage synchroniser, programmable glitch filter, rise/fall edge detection, sticky maskable event flags.

---
 rtl/pad_in_filter.sv | 106 ++++++++++
 1 files changed

// File: rtl/pad_in_filter.sv
// ============================================================================
//  Module   : pad_in_filter
//  Purpose  : Per-channel pad input conditioning: synchroniser, glitch filter,
//             edge detection and sticky maskable event flags with interrupt.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pad_in_filter #(
    parameter int                NUM_IN      = 32,
    parameter int                CNT_W       = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [NUM_IN-1:0] RST_VAL     = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_IN-1:0] pad_in_i,
    input  logic [NUM_IN-1:0] filt_en_i,
    input  logic [CNT_W-1:0]  filt_len_i,
    input  logic [NUM_IN-1:0] evt_mask_i,
    input  logic [NUM_IN-1:0] evt_clr_i,
    output logic [NUM_IN-1:0] in_filt_o,
    output logic [NUM_IN-1:0] rise_o,
    output logic [NUM_IN-1:0] fall_o,
    output logic [NUM_IN-1:0] evt_pend_o,
    output logic              irq_o
);

    logic [NUM_IN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IN-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0]  cnt_q  [NUM_IN];
    logic [CNT_W-1:0]  cnt_d  [NUM_IN];
    logic [NUM_IN-1:0] filt_q, filt_d;
    logic [NUM_IN-1:0] prev_q, prev_d;
    logic [NUM_IN-1:0] pend_q, pend_d;
    logic [NUM_IN-1:0] w_sync;

    // Plain flop chain: nothing may sit between stages or metastability leaks.
    always_comb begin
        sync_d[0] = pad_in_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign w_sync = sync_q[SYNC_STAGES-1];

    // A mismatch must survive L+1 consecutive cycles; >= lets a lowered L
    // take effect on the very next mismatch cycle.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!filt_en_i[i]) begin
                filt_d[i] = w_sync[i];
                cnt_d[i]  = '0;
            end else if (w_sync[i] == filt_q[i]) begin
                cnt_d[i]  = '0;
            end else if (cnt_q[i] >= filt_len_i) begin
                filt_d[i] = w_sync[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i]  = cnt_q[i] + 1'b1;
            end
        end
    end

    assign rise_o = filt_q & ~prev_q;
    assign fall_o = ~filt_q & prev_q;

    always_comb begin
        prev_d = filt_q;
        pend_d = (pend_q & ~evt_clr_i) | (evt_mask_i & (rise_o | fall_o));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
            filt_q <= RST_VAL;
            prev_q <= RST_VAL;
            pend_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            filt_q <= filt_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign in_filt_o  = filt_q;
    assign evt_pend_o = pend_q;
    assign irq_o      = |pend_q;

endmodule

`default_nettype wire
